// File: rtl/dda_out_pkg.sv
// dda_out_pkg
// Shared definitions for the DDA-out beat. The transformation module unpacks
// the same fields, so field widths and order must only change here.
//   - field width constants (HCOUNT_W, LINEH_W, MAPDATA_W, WALLX_W)
//   - dda_out_beat_t : packed beat, MSB first, identical to tdata layout
//   - pattern_mode_t : pattern select of the synthetic generator
//   - lfsr_step      : one step of the 16-bit Fibonacci LFSR
package dda_out_pkg;

    localparam int HCOUNT_W  = 9;
    localparam int LINEH_W   = 8;
    localparam int MAPDATA_W = 4;
    localparam int WALLX_W   = 16;
    localparam int BEAT_W    = HCOUNT_W + LINEH_W + 1 + MAPDATA_W + WALLX_W;

    typedef struct packed {
        logic [HCOUNT_W-1:0]  hcount;     // [37:29]
        logic [LINEH_W-1:0]   lineheight; // [28:21]
        logic                 wall_type;  // [20]
        logic [MAPDATA_W-1:0] mapdata;    // [19:16]
        logic [WALLX_W-1:0]   wallx;      // [15:0]
    } dda_out_beat_t;

    typedef enum logic [1:0] {
        MODE_CONST    = 2'd0,
        MODE_RAMP     = 2'd1,
        MODE_TRIANGLE = 2'd2,
        MODE_LFSR     = 2'd3
    } pattern_mode_t;

    // Taps 16,14,13,11 (bits 15,13,12,10): maximal-length sequence.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/dda_out_pattern_gen_lfsr16.sv
// lfsr16
// 16-bit Fibonacci LFSR that steps only when asked. Reloads SEED on reset only.
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset
//   advance in   step the register this cycle
//   state   out  current 16-bit LFSR value
module lfsr16
    import dda_out_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/dda_out_pattern_gen.sv
// dda_out_pattern_gen
// Synthetic AXI-Stream source standing in for the DDA during bring-up. Each
// start_in pulse emits one frame of SCREEN_WIDTH per-column beats, hcount
// 0..SCREEN_WIDTH-1, honouring full tready backpressure.
//
// Build option: define PATTERN_LFSR_EN to make mode 3 an LFSR pattern (and
// instantiate lfsr16). Without it no LFSR logic exists and mode 3 behaves
// exactly like mode 0.
//
// Ports:
//   pixel_clk_in        in   sole clock
//   rst_in              in   synchronous active-high reset
//   start_in            in   one-cycle frame request (ignored while busy)
//   mode_in[1:0]        in   pattern select, latched at frame start
//   dda_fsm_out_tready  in   sink ready
//   dda_fsm_out_tvalid  out  beat valid
//   dda_fsm_out_tdata   out  beat payload (dda_out_beat_t layout)
//   dda_fsm_out_tlast   out  high on the final column's beat
//   busy_out            out  frame in progress
//   frame_done_out      out  one-cycle pulse after the last beat is accepted
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. Once tvalid is raised it stays high, and tdata/tlast stay
// unchanged, until that transfer happens.
module dda_out_pattern_gen
    import dda_out_pkg::*;
#(
    parameter int          SCREEN_WIDTH  = 320,
    parameter int          SCREEN_HEIGHT = 240,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic               pixel_clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic [1:0]         mode_in,
    input  logic               dda_fsm_out_tready,
    output logic               dda_fsm_out_tvalid,
    output logic [BEAT_W-1:0]  dda_fsm_out_tdata,
    output logic               dda_fsm_out_tlast,
    output logic               busy_out,
    output logic               frame_done_out
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam logic [HCOUNT_W-1:0] LAST_H = HCOUNT_W'(SCREEN_WIDTH - 1);

    logic [0:0]          state;
    logic [HCOUNT_W-1:0] hcount;
    pattern_mode_t       mode_q;
    dda_out_beat_t       beat_q;

    logic                handshake;
    logic [HCOUNT_W-1:0] next_h;
    pattern_mode_t       mode_sel;
    logic [LINEH_W-1:0]  lineh;
    dda_out_beat_t       next_beat;

    assign handshake = (state == SEND) && dda_fsm_out_tready;

`ifdef PATTERN_LFSR_EN
    logic [15:0]        lfsr_state;
    logic [LINEH_W-1:0] lfsr_byte;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (pixel_clk_in),
        .rst     (rst_in),
        .advance (handshake && (mode_q == MODE_LFSR)),
        .state   (lfsr_state)
    );

    // Beat 0 shows the current LFSR value; every later beat is registered on
    // the handshake that also steps the LFSR, so it must use the stepped value.
    assign lfsr_byte = (state == IDLE) ? lfsr_state[7:0] : 8'(lfsr_step(lfsr_state));
`endif

    // The next beat to register: beat 0 when starting from IDLE, otherwise
    // the beat after the one currently presented.
    always_comb begin
        next_h   = '0;
        mode_sel = mode_q;
        if (state == IDLE) begin
            next_h   = '0;
            mode_sel = pattern_mode_t'(mode_in);
        end else begin
            next_h = hcount + 1'b1;
        end

        lineh = LINEH_W'(120);
        case (mode_sel)
            MODE_CONST: lineh = LINEH_W'(120);
            MODE_RAMP:  lineh = LINEH_W'(next_h >> 1);
            MODE_TRIANGLE: begin
                if (next_h < 9'd160) lineh = LINEH_W'(next_h + 9'd40);
                else                 lineh = LINEH_W'(9'd359 - next_h);
            end
            MODE_LFSR: begin
`ifdef PATTERN_LFSR_EN
                if (int'(lfsr_byte) >= SCREEN_HEIGHT) lineh = LINEH_W'(SCREEN_HEIGHT - 1);
                else                                  lineh = lfsr_byte;
`else
                lineh = LINEH_W'(120);
`endif
            end
            default: lineh = LINEH_W'(120);
        endcase

        next_beat.hcount     = next_h;
        next_beat.lineheight = lineh;
        next_beat.wall_type  = next_h[5];
        next_beat.mapdata    = {1'b0, next_h[8:6]} + 4'd1;
        next_beat.wallx      = {next_h[4:0], 11'b0};
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state              <= IDLE;
            hcount             <= '0;
            mode_q             <= MODE_CONST;
            beat_q             <= '0;
            dda_fsm_out_tvalid <= 1'b0;
            dda_fsm_out_tlast  <= 1'b0;
            busy_out           <= 1'b0;
            frame_done_out     <= 1'b0;
        end else begin
            frame_done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        state              <= SEND;
                        mode_q             <= mode_sel;
                        hcount             <= next_h;
                        beat_q             <= next_beat;
                        dda_fsm_out_tvalid <= 1'b1;
                        dda_fsm_out_tlast  <= (next_h == LAST_H);
                        busy_out           <= 1'b1;
                    end
                end
                SEND: begin
                    // start_in is deliberately not looked at here.
                    if (handshake) begin
                        if (hcount == LAST_H) begin
                            state              <= IDLE;
                            dda_fsm_out_tvalid <= 1'b0;
                            dda_fsm_out_tlast  <= 1'b0;
                            busy_out           <= 1'b0;
                            frame_done_out     <= 1'b1;
                        end else begin
                            hcount            <= next_h;
                            beat_q            <= next_beat;
                            dda_fsm_out_tlast <= (next_h == LAST_H);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dda_fsm_out_tdata = beat_q;

endmodule

// File: tb/tb_dda_out_pattern_gen.sv
// tb_dda_out_pattern_gen
// Self-checking bench for dda_out_pattern_gen (default parameters). Expected
// beats come from a column-level model of the pattern rules. Honours the
// PATTERN_LFSR_EN build option the same way the design does.
module tb_dda_out_pattern_gen;

    localparam int W = 320;
    localparam int H = 240;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        start_in = 1'b0;
    logic [1:0]  mode_in = 2'd0;
    logic        tready = 1'b0;
    logic        tvalid;
    logic [37:0] tdata;
    logic        tlast;
    logic        busy;
    logic        frame_done;

    int compared = 0;
    int mismatched = 0;

    logic [37:0] exp_q[$];
    logic [37:0] got_q[$];
    bit          last_q[$];
    logic [15:0] model_lfsr = SEED;
    int          stall_errs;
    bit          timed_out;
    int          cycles;
    logic        valid_at_start;
    logic        busy_at_start;

    dda_out_pattern_gen dut (
        .pixel_clk_in       (clk),
        .rst_in             (rst_in),
        .start_in           (start_in),
        .mode_in            (mode_in),
        .dda_fsm_out_tready (tready),
        .dda_fsm_out_tvalid (tvalid),
        .dda_fsm_out_tdata  (tdata),
        .dda_fsm_out_tlast  (tlast),
        .busy_out           (busy),
        .frame_done_out     (frame_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic int model_lh(input int h, input int mode, input logic [15:0] lf);
        case (mode)
            0: return 120;
            1: return h / 2;
            2: return (h < 160) ? h + 40 : 359 - h;
            default: begin
`ifdef PATTERN_LFSR_EN
                return (int'(lf[7:0]) >= H) ? H - 1 : int'(lf[7:0]);
`else
                return 120;
`endif
            end
        endcase
    endfunction

    function automatic logic [37:0] model_beat(input int h, input int mode, input logic [15:0] lf);
        logic [8:0]  f_h;
        logic [7:0]  f_lh;
        logic        f_wt;
        logic [3:0]  f_md;
        logic [15:0] f_wx;
        f_h  = 9'(h);
        f_lh = 8'(model_lh(h, mode, lf));
        f_wt = 1'((h / 32) % 2);
        f_md = 4'(h / 64 + 1);
        f_wx = 16'((h % 32) * 2048);
        return {f_h, f_lh, f_wt, f_md, f_wx};
    endfunction

    task automatic build_exp(input int mode);
        exp_q.delete();
        for (int h = 0; h < W; h++) begin
            exp_q.push_back(model_beat(h, mode, model_lfsr));
            if (mode == 3) model_lfsr = model_step(model_lfsr);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_in = 1'b1; start_in = 1'b0; tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_in = 1'b0;
        model_lfsr = SEED;
    endtask

    task automatic do_start(input int mode);
        @(posedge clk); #1;
        start_in = 1'b1;
        mode_in  = 2'(mode);
        @(posedge clk); #1;
        start_in = 1'b0;
    endtask

    // Collects accepted beats until the tlast beat is accepted. Returns just
    // after the edge of the final handshake (cycle M+1). Optional hooks:
    // poke_at raises start_in and flips mode_in once poke_at beats were taken;
    // rst_at raises rst_in once rst_at beats were taken and returns early;
    // start_on_last raises start_in during the final handshake cycle.
    task automatic capture(input int ready_pct, input int poke_at, input int rst_at,
                           input bit start_on_last);
        bit          fin = 1'b0;
        bit          prev_stall = 1'b0;
        bit          poked = 1'b0;
        logic [37:0] prev_data = '0;
        got_q.delete();
        last_q.delete();
        stall_errs = 0;
        timed_out  = 1'b1;
        cycles     = 0;
        for (int c = 0; c < 4000; c++) begin
            tready = ($urandom_range(0, 99) < ready_pct);
            @(negedge clk);
            cycles++;
            if (c == 0) begin
                valid_at_start = tvalid;
                busy_at_start  = busy;
            end
            if (prev_stall && (tdata !== prev_data)) stall_errs++;
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            if (tvalid && tready) begin
                got_q.push_back(tdata);
                last_q.push_back(tlast);
                if (tlast) fin = 1'b1;
            end
            if (fin && start_on_last) start_in = 1'b1;
            @(posedge clk); #1;
            start_in = 1'b0;
            if (fin) begin
                timed_out = 1'b0;
                break;
            end
            if (poke_at >= 0 && !poked && got_q.size() == poke_at) begin
                start_in = 1'b1;
                mode_in  = ~mode_in;
                poked    = 1'b1;
            end
            if (rst_at >= 0 && got_q.size() == rst_at) begin
                rst_in    = 1'b1;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        compared++;
        if (tvalid !== 1'b0 || tdata !== 38'd0 || tlast !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b b=%b fd=%b required all zero",
                     tvalid, tdata, tlast, busy, frame_done);
        end
    endtask

    task automatic test_ramp_full_rate();
        int shown = 0;
        build_exp(1);
        do_start(1);
        capture(100, -1, -1, 1'b0);
        compared++;
        if (valid_at_start !== 1'b1 || busy_at_start !== 1'b1) begin
            mismatched++;
            $display("FAIL ramp_start_latency: got tvalid=%b busy=%b required 1 1", valid_at_start, busy_at_start);
        end
        compared++;
        if (timed_out || got_q.size() != W || cycles != W) begin
            mismatched++;
            $display("FAIL ramp_count: got beats=%0d cycles=%0d timeout=%0b required %0d %0d 0",
                     got_q.size(), cycles, timed_out, W, W);
        end
        for (int i = 0; i < W; i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++;
                if (shown++ < 8) $display("FAIL ramp_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        compared++;
        if (got_q[0][37:29] !== 9'd0 || got_q[0][28:21] !== 8'd0) begin
            mismatched++;
            $display("FAIL ramp_beat0: got hc=%0d lh=%0d required 0 0", got_q[0][37:29], got_q[0][28:21]);
        end
        compared++;
        if (got_q[W-1][37:29] !== 9'd319 || got_q[W-1][28:21] !== 8'd159 || last_q[W-1] !== 1'b1) begin
            mismatched++;
            $display("FAIL ramp_beat319: got hc=%0d lh=%0d last=%b required 319 159 1",
                     got_q[W-1][37:29], got_q[W-1][28:21], last_q[W-1]);
        end
        @(negedge clk);
        compared++;
        if (frame_done !== 1'b1 || tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL ramp_done_pulse: got fd=%b v=%b l=%b b=%b required 1 0 0 0", frame_done, tvalid, tlast, busy);
        end
        @(negedge clk);
        compared++;
        if (frame_done !== 1'b0) begin
            mismatched++;
            $display("FAIL ramp_done_width: got fd=%b required 0", frame_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int shown = 0;
        int bad_last = 0;
        build_exp(0);
        do_start(0);
        capture(50, -1, -1, 1'b0);
        compared++;
        if (stall_errs != 0) begin
            mismatched++;
            $display("FAIL bp_stable: got %0d changes during stall required 0", stall_errs);
        end
        compared++;
        if (timed_out || got_q.size() != W) begin
            mismatched++;
            $display("FAIL bp_count: got beats=%0d timeout=%0b required %0d 0", got_q.size(), timed_out, W);
        end
        for (int i = 0; i < W; i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++;
                if (shown++ < 8) $display("FAIL bp_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
            if (i < last_q.size() && last_q[i] !== (i == W - 1)) bad_last++;
        end
        compared++;
        if (bad_last != 0) begin
            mismatched++;
            $display("FAIL bp_tlast: got %0d misplaced tlast required 0", bad_last);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_triangle();
        int shown = 0;
        build_exp(2);
        do_start(2);
        capture(70, -1, -1, 1'b0);
        compared++;
        if (timed_out || got_q.size() != W) begin
            mismatched++;
            $display("FAIL tri_count: got beats=%0d required %0d", got_q.size(), W);
        end
        compared++;
        if (got_q[0][28:21] !== 8'd40 || got_q[159][28:21] !== 8'd199 ||
            got_q[160][28:21] !== 8'd199 || got_q[319][28:21] !== 8'd40) begin
            mismatched++;
            $display("FAIL tri_points: got %0d %0d %0d %0d required 40 199 199 40",
                     got_q[0][28:21], got_q[159][28:21], got_q[160][28:21], got_q[319][28:21]);
        end
        for (int i = 0; i < W; i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++;
                if (shown++ < 8) $display("FAIL tri_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_packing();
        logic [37:0] b;
        build_exp(1);
        do_start(1);
        capture(80, -1, -1, 1'b0);
        b = got_q[37];
        compared++;
        if (b[37:29] !== 9'd37 || b[28:21] !== 8'd18 || b[20] !== 1'b1 ||
            b[19:16] !== 4'd1 || b[15:0] !== 16'h2800) begin
            mismatched++;
            $display("FAIL pack_beat37: got hc=%0d lh=%0d wt=%b md=%0d wx=%h required 37 18 1 1 2800",
                     b[37:29], b[28:21], b[20], b[19:16], b[15:0]);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_mode3();
        int shown = 0;
        int over = 0;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            build_exp(3);
            do_start(3);
            capture(60, -1, -1, 1'b0);
            compared++;
            if (timed_out || got_q.size() != W) begin
                mismatched++;
                $display("FAIL m3_count[%0d]: got beats=%0d required %0d", f, got_q.size(), W);
            end
            for (int i = 0; i < W; i++) begin
                compared++;
                if (got_q[i] !== exp_q[i]) begin
                    mismatched++;
                    if (shown++ < 8) $display("FAIL m3_beat[%0d][%0d]: got %h required %h", f, i, got_q[i], exp_q[i]);
                end
                if (i < got_q.size() && got_q[i][28:21] > 8'd239) over++;
            end
            if (f == 0) begin
                compared++;
`ifdef PATTERN_LFSR_EN
                if (got_q[0][28:21] !== 8'd225) begin
                    mismatched++;
                    $display("FAIL m3_beat0: got lh=%0d required 225", got_q[0][28:21]);
                end
`else
                if (got_q[0][28:21] !== 8'd120) begin
                    mismatched++;
                    $display("FAIL m3_beat0: got lh=%0d required 120", got_q[0][28:21]);
                end
`endif
            end
            repeat (2) @(posedge clk);
            #1;
        end
        compared++;
        if (over != 0) begin
            mismatched++;
            $display("FAIL m3_clamp: got %0d beats above 239 required 0", over);
        end
    endtask

    task automatic test_ignore_start();
        int shown = 0;
        build_exp(2);
        do_start(2);
        capture(75, 100, -1, 1'b0);
        compared++;
        if (timed_out || got_q.size() != W) begin
            mismatched++;
            $display("FAIL ign_count: got beats=%0d required %0d", got_q.size(), W);
        end
        for (int i = 0; i < W; i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++;
                if (shown++ < 8) $display("FAIL ign_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (tvalid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL ign_no_restart: got v=%b b=%b required 0 0", tvalid, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        int shown = 0;
        do_start(1);
        capture(65, -1, 200, 1'b0);
        @(posedge clk); #1;
        rst_in = 1'b0;
        model_lfsr = SEED;
        @(negedge clk);
        compared++;
        if (tvalid !== 1'b0 || tdata !== 38'd0 || tlast !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid: got v=%b d=%h l=%b b=%b fd=%b required all zero",
                     tvalid, tdata, tlast, busy, frame_done);
        end
        @(posedge clk); #1;
        build_exp(1);
        do_start(1);
        capture(100, -1, -1, 1'b0);
        compared++;
        if (timed_out || got_q.size() != W || got_q[0][37:29] !== 9'd0) begin
            mismatched++;
            $display("FAIL rst_restart: got beats=%0d first_hc=%0d required %0d 0", got_q.size(), got_q[0][37:29], W);
        end
        for (int i = 0; i < W; i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++;
                if (shown++ < 8) $display("FAIL rst_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Start during the final handshake cycle is ignored.
        build_exp(0);
        do_start(0);
        capture(100, -1, -1, 1'b1);
        @(negedge clk);
        compared++;
        if (frame_done !== 1'b1 || tvalid !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_done: got fd=%b v=%b required 1 0", frame_done, tvalid);
        end
        @(negedge clk);
        compared++;
        if (tvalid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_coincident_ignored: got v=%b b=%b required 0 0", tvalid, busy);
        end
        @(posedge clk); #1;
        // Start in the frame_done cycle (M+1) is accepted.
        build_exp(2);
        do_start(2);
        capture(100, -1, -1, 1'b0);
        start_in = 1'b1;
        mode_in  = 2'd1;
        @(negedge clk);
        compared++;
        if (frame_done !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_done2: got fd=%b required 1", frame_done);
        end
        @(posedge clk); #1;
        start_in = 1'b0;
        build_exp(1);
        capture(100, -1, -1, 1'b0);
        compared++;
        if (valid_at_start !== 1'b1 || timed_out || got_q.size() != W || got_q[W-1] !== exp_q[W-1] || got_q[0] !== exp_q[0]) begin
            mismatched++;
            $display("FAIL b2b_restart: got v=%b beats=%0d first=%h required 1 %0d %h",
                     valid_at_start, got_q.size(), got_q[0], W, exp_q[0]);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_ramp_full_rate();
        test_backpressure();
        test_triangle();
        test_packing();
        test_mode3();
        test_ignore_start();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
